// File: rtl/io_fabric_pkg.sv
// io_fabric_pkg: shared FSM type, internal register offsets and error data for io_fabric
package io_fabric_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [1:0] REG_IRQ_MASK = 2'd0;
  localparam logic [1:0] REG_IRQ_RAW = 2'd1;
  localparam logic [1:0] REG_ERR_ADDR = 2'd2;
  localparam logic [31:0] ERR_DATA = 32'h0;
endpackage

// File: rtl/io_fabric_decode.sv
// io_decode: base/mask priority address decoder; the control window beats every channel
module io_decode
  import io_fabric_pkg::*;
#(
  parameter int NSLAVES = 8,
  parameter int ADDR_WIDTH = 11,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] BASES = '0,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] MASKS = '0,
  parameter logic [ADDR_WIDTH-1:0] CTRL_BASE = 11'h7f0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [NSLAVES-1:0]    onehot_o,
  output logic                  ctrl_hit_o
);
  logic [NSLAVES-1:0] pri;
  always_comb begin
    pri = '0;
    for (int i = NSLAVES - 1; i >= 0; i--)
      if ((addr_i & MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) == BASES[i*ADDR_WIDTH +: ADDR_WIDTH])
        pri = NSLAVES'(1) << i;
  end
  assign ctrl_hit_o = addr_i[ADDR_WIDTH-1:4] == CTRL_BASE[ADDR_WIDTH-1:4];
  assign onehot_o = ctrl_hit_o ? '0 : pri;
  assign hit_o = ctrl_hit_o | (|pri);
endmodule

// File: rtl/io_fabric.sv
// io_fabric: CPU I/O bus bridge to NSLAVES channels with timeout, bus errors and masked IRQs
module io_fabric
  import io_fabric_pkg::*;
#(
  parameter int NSLAVES = 8,
  parameter int ADDR_WIDTH = 11,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] BASES = '0,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] MASKS = '0,
  parameter logic [ADDR_WIDTH-1:0] CTRL_BASE = 11'h7f0,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [31:0]             data_in,
  input  logic [3:0]              be,
  output logic [31:0]             data_out,
  output logic                    ack,
  output logic                    err,
  output logic [NSLAVES-1:0]      s_sel,
  output logic                    s_read,
  output logic                    s_write,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic [31:0]             s_data_in,
  output logic [3:0]              s_be,
  input  logic [NSLAVES*32-1:0]   s_data_out,
  input  logic [NSLAVES-1:0]      s_ack,
  input  logic [NSLAVES-1:0]      irq_in,
  output logic                    irq_out
);
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [NSLAVES-1:0] sel_q, sel_d, onehot;
  logic ctrl_q, ctrl_d, rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [31:0] wdata_q, wdata_d, data_q, data_d, mask_q, mask_d;
  logic [3:0] be_q, be_d;
  logic ack_q, ack_d, err_q, err_d, irq_q;
  logic hit, ctrl_hit, s_done;
  logic [31:0] s_rdata, c_rdata;
  io_decode #(
    .NSLAVES(NSLAVES), .ADDR_WIDTH(ADDR_WIDTH), .BASES(BASES), .MASKS(MASKS), .CTRL_BASE(CTRL_BASE)
  ) u_dec (
    .addr_i(address), .hit_o(hit), .onehot_o(onehot), .ctrl_hit_o(ctrl_hit)
  );
  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < NSLAVES; i++)
      if (sel_q[i]) s_rdata = s_data_out[i*32 +: 32];
  end
  always_comb
    c_rdata = addr_q[3:2] == REG_IRQ_MASK ? mask_q :
              addr_q[3:2] == REG_IRQ_RAW  ? 32'(irq_in) :
              addr_q[3:2] == REG_ERR_ADDR ? 32'(err_addr_q) : '0;
  // internal registers never wait, so a control access completes on its first ACCESS cycle
  assign s_done = ctrl_q | (|(s_ack & sel_q));
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    sel_d = sel_q;
    ctrl_d = ctrl_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    data_d = data_q;
    mask_d = mask_q;
    err_addr_d = err_addr_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (read | write) begin
        addr_d = address;
        wdata_d = data_in;
        be_d = be;
        rd_d = read;
        wr_d = write;
        sel_d = onehot;
        ctrl_d = ctrl_hit;
        if (!hit || (read && write)) begin
          state_d = DONE;
          ack_d = 1'b1;
          err_d = 1'b1;
          err_addr_d = address;
          data_d = read ? ERR_DATA : data_q;
        end else state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q == 8'hff ? cnt_q : cnt_q + 8'd1;
        if (s_done) begin
          state_d = DONE;
          ack_d = 1'b1;
          data_d = !rd_q ? data_q : ctrl_q ? c_rdata : s_rdata;
          if (ctrl_q && wr_q && addr_q[3:2] == REG_IRQ_MASK)
            for (int b = 0; b < 4; b++) mask_d[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8] : mask_q[b*8 +: 8];
        end else if (cnt_q == TLIM) begin
          state_d = DONE;
          ack_d = 1'b1;
          err_d = 1'b1;
          err_addr_d = addr_q;
          data_d = rd_q ? ERR_DATA : data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      ctrl_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      err_addr_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      ctrl_q <= ctrl_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      data_q <= data_d;
      mask_q <= mask_d;
      err_addr_q <= err_addr_d;
      ack_q <= ack_d;
      err_q <= err_d;
      irq_q <= |(irq_in & mask_q[NSLAVES-1:0]);
    end
  assign s_sel = state_q == ACCESS ? sel_q : '0;
  assign s_read = state_q == ACCESS && rd_q && !ctrl_q;
  assign s_write = state_q == ACCESS && wr_q && !ctrl_q;
  assign s_address = addr_q;
  assign s_data_in = wdata_q;
  assign s_be = be_q;
  assign data_out = data_q;
  assign ack = ack_q;
  assign err = err_q;
  assign irq_out = irq_q;
endmodule

// File: tb/tb_io_fabric.sv
// tb_io_fabric: directed transactions against a transaction-level model of io_fabric
module tb_io_fabric;
  localparam int NS = 8;
  localparam int AW = 11;
  localparam int TO = 4;
  localparam logic [AW-1:0] CTRL = 11'h7f0;
  localparam logic [NS*AW-1:0] BASES = {11'h180, 11'h140, 11'h100, 11'h700, 11'h020, 11'h040, 11'h020, 11'h000};
  localparam logic [NS*AW-1:0] MASKS = {11'h7f0, 11'h7f0, 11'h7f0, 11'h700, 11'h7e0, 11'h7f0, 11'h7f0, 11'h7f8};
  int waits [NS] = '{0, 3, -1, 1, 0, 2, 4, 0};
  logic clk = 0, rst_n = 0, read = 0, write = 0;
  logic [AW-1:0] address = '0;
  logic [31:0] data_in = '0, data_out;
  logic [3:0] be = '0, s_be;
  logic ack, err, s_read, s_write, irq_out;
  logic [NS-1:0] s_sel, s_ack, irq_in = '0, noise = '0;
  logic [AW-1:0] s_address;
  logic [31:0] s_data_in;
  logic [NS*32-1:0] s_data_out;
  int acc_cyc = 0, n_chk = 0, n_fail = 0;
  logic chk_en = 0;
  logic m_busy = 0, m_rd, m_wr, m_err, m_strobe, m_mwr, prev_irq;
  int m_cyc = 0, m_lat, m_tgt;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wd, m_dold = 0, m_dnew, m_mold = 0, m_mnew, m_eaold = 0, m_eanew;
  logic [3:0] m_be;
  int t_lat, t_strb;
  logic t_irq_a, t_irq_b;

  io_fabric #(
    .NSLAVES(NS), .ADDR_WIDTH(AW), .BASES(BASES), .MASKS(MASKS), .CTRL_BASE(CTRL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address), .data_in(data_in),
    .be(be), .data_out(data_out), .ack(ack), .err(err), .s_sel(s_sel), .s_read(s_read),
    .s_write(s_write), .s_address(s_address), .s_data_in(s_data_in), .s_be(s_be),
    .s_data_out(s_data_out), .s_ack(s_ack), .irq_in(irq_in), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sdata(input int i);
    return i == 0 ? 32'hCAFEF00D : 32'hA5000000 | (32'(i) * 32'h0101);
  endfunction

  always_comb
    for (int i = 0; i < NS; i++) s_data_out[i*32 +: 32] = sdata(i);
  always_comb
    for (int i = 0; i < NS; i++) s_ack[i] = noise[i] | (s_sel[i] && waits[i] >= 0 && acc_cyc == waits[i]);
  always @(posedge clk) acc_cyc <= (s_sel != 0) ? acc_cyc + 1 : 0;
  always @(posedge clk) m_cyc <= m_busy ? m_cyc + 1 : 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model's view of the current transaction
  always @(negedge clk) begin
    logic live;
    logic [31:0] msk;
    if (!rst_n) prev_irq = 1'b0;
    else begin
      live = m_busy && m_cyc >= 1 && m_cyc < m_lat && m_strobe;
      if (chk_en) begin
        check("ack", {31'b0, ack}, {31'b0, m_busy && m_cyc == m_lat});
        if (m_busy && m_cyc == m_lat) check("err", {31'b0, err}, {31'b0, m_err});
        check("s_sel", {24'b0, s_sel}, live ? 32'(1) << m_tgt : 32'h0);
        check("s_read", {31'b0, s_read}, {31'b0, live && m_rd});
        check("s_write", {31'b0, s_write}, {31'b0, live && m_wr});
        if (live) begin
          check("s_address", {21'b0, s_address}, {21'b0, m_addr});
          check("s_data_in", s_data_in, m_wd);
          check("s_be", {28'b0, s_be}, {28'b0, m_be});
        end
        check("data_out", data_out, (m_busy && m_cyc >= m_lat) ? m_dnew : m_dold);
        check("irq_out", {31'b0, irq_out}, {31'b0, prev_irq});
      end
      msk = (m_busy && m_mwr && m_cyc >= m_lat) ? m_mnew : m_mold;
      prev_irq = |(irq_in & msk[NS-1:0]);
    end
  end

  task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] b);
    int tgt;
    logic ctrl;
    ctrl = a[AW-1:4] == CTRL[AW-1:4];
    tgt = -1;
    if (!ctrl)
      for (int i = 0; i < NS; i++)
        if (tgt < 0 && (a & MASKS[i*AW +: AW]) == BASES[i*AW +: AW]) tgt = i;
    m_rd = rd; m_wr = wr; m_addr = a; m_wd = wd; m_be = b; m_tgt = tgt;
    m_strobe = 0; m_mwr = 0; m_err = 0;
    m_dnew = m_dold; m_mnew = m_mold; m_eanew = m_eaold;
    if ((rd && wr) || (!ctrl && tgt < 0)) begin
      m_lat = 1; m_err = 1; m_eanew = 32'(a);
      if (rd) m_dnew = 0;
    end else if (ctrl) begin
      m_lat = 2;
      if (rd) m_dnew = a[3:2] == 0 ? m_mold : a[3:2] == 1 ? 32'(irq_in) : a[3:2] == 2 ? m_eaold : 0;
      if (wr && a[3:2] == 0) begin
        m_mwr = 1;
        for (int k = 0; k < 4; k++) if (b[k]) m_mnew[k*8 +: 8] = wd[k*8 +: 8];
      end
    end else begin
      m_strobe = 1;
      if (waits[tgt] >= 0 && waits[tgt] + 1 <= TO) begin
        m_lat = waits[tgt] + 2;
        if (rd) m_dnew = sdata(tgt);
      end else begin
        m_lat = TO + 1; m_err = 1; m_eanew = 32'(a);
        if (rd) m_dnew = 0;
      end
    end
    @(posedge clk); #1;
    read = rd; write = wr; address = a; data_in = wd; be = b; m_busy = 1;
    t_lat = -1; t_strb = 0; t_irq_a = 0;
    for (int c = 1; c <= 64 && t_lat < 0; c++) begin
      @(posedge clk); #1;
      if (s_read | s_write) t_strb++;
      if (ack) begin
        t_lat = c; t_irq_a = irq_out; read = 0; write = 0;
      end
    end
    if (t_lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL ack_wait: no ack within 64 cycles for address %h", a);
      read = 0; write = 0;
    end
    @(posedge clk); #1;
    t_irq_b = irq_out;
    @(negedge clk); #1;
    m_dold = m_dnew; m_mold = m_mnew; m_eaold = m_eanew; m_busy = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_ack_err", {30'b0, ack, err}, 0);
    check("rst_strobes", {22'b0, s_sel, s_read, s_write}, 0);
    check("rst_s_addr", {21'b0, s_address}, 0);
    check("rst_s_data_in", s_data_in, 0);
    check("rst_s_be_irq", {27'b0, s_be, irq_out}, 0);
    rst_n = 1;
    chk_en = 1;
    xfer(1, 0, 11'h004, 0, 4'hf);
    check("t1_lat", t_lat, 2);
    check("t1_data", data_out, 32'hCAFEF00D);
    xfer(0, 1, 11'h020, 32'h12345678, 4'ha);
    check("t2_lat", t_lat, 5);
    check("t2_strobe_cycles", t_strb, 4);
    xfer(1, 0, 11'h300, 0, 4'hf);
    check("t3_lat", t_lat, 1);
    check("t3_data", data_out, 0);
    xfer(1, 0, 11'h7f8, 0, 4'hf);
    check("t3_err_addr", data_out, 32'h300);
    noise = 8'hfb;
    xfer(1, 0, 11'h044, 0, 4'hf);
    noise = 0;
    check("t4_timeout_lat", t_lat, 5);
    xfer(1, 0, 11'h148, 0, 4'hf);
    xfer(1, 0, 11'h7f8, 0, 4'hf);
    check("t4_err_addr", data_out, 32'h148);
    xfer(1, 0, 11'h030, 0, 4'hf);
    check("prio_ch3", data_out, 32'hA5000303);
    xfer(1, 0, 11'h028, 0, 4'hf);
    check("prio_ch1", data_out, 32'hA5000101);
    xfer(1, 0, 11'h704, 0, 4'hf);
    xfer(0, 1, 11'h104, 32'hdeadbeef, 4'h3);
    irq_in = 8'h06;
    xfer(1, 0, 11'h7f4, 0, 4'hf);
    check("irq_raw", data_out, 32'h06);
    xfer(0, 1, 11'h7f0, 32'h04, 4'hf);
    check("irq_at_ack", {31'b0, t_irq_a}, 0);
    check("irq_after_ack", {31'b0, t_irq_b}, 1);
    xfer(0, 1, 11'h7f0, 32'hffffffff, 4'h2);
    xfer(1, 0, 11'h7f0, 0, 4'hf);
    check("mask_bytes", data_out, 32'h0000ff04);
    xfer(1, 1, 11'h004, 0, 4'hf);
    check("rw_err_lat", t_lat, 1);
    xfer(1, 0, 11'h004, 0, 4'hf);
    xfer(0, 1, 11'h7fc, 32'h55, 4'hf);
    xfer(1, 0, 11'h7fc, 0, 4'hf);
    check("reserved_reg", data_out, 0);
    chk_en = 0;
    @(posedge clk); #1;
    read = 1; address = 11'h044;
    repeat (2) @(posedge clk);
    #1;
    check("mid_sel", {24'b0, s_sel}, 32'h04);
    rst_n = 0;
    #1;
    check("rst_mid_sel", {24'b0, s_sel}, 0);
    check("rst_mid_read", {31'b0, s_read}, 0);
    read = 0;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'b0, ack}, 0);
    rst_n = 1;
    m_dold = 0; m_mold = 0; m_eaold = 0;
    @(posedge clk); #1;
    check("post_rst_ack", {31'b0, ack}, 0);
    @(negedge clk); #1;
    chk_en = 1;
    xfer(1, 0, 11'h004, 0, 4'hf);
    check("restart_lat", t_lat, 2);
    check("restart_data", data_out, 32'hCAFEF00D);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
